// File: rtl/pipeline_stage_buffer_pkg.sv
// Shared state encoding and default widths for the generic inter-stage pipeline register.
package pipeline_stage_buffer_pkg;

    typedef enum logic [1:0] {
        PSB_EMPTY   = 2'd0,
        PSB_FULL    = 2'd1,
        PSB_SKIDDED = 2'd2
    } psb_state_e;

    localparam int PSB_DATA_W = 32;
    localparam int PSB_CTRL_W = 8;
    localparam int PSB_CNT_W  = 16;

endpackage

// File: rtl/pipeline_stage_buffer_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; cleared only by reset.
module pipeline_stage_buffer_sat_counter
    import pipeline_stage_buffer_pkg::*;
#(
    parameter int WIDTH = PSB_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_stage_buffer.sv
// Generic valid/ready pipeline register with flush-to-bubble, optional 2-entry skid
// buffer and saturating stall/flush counters.
module pipeline_stage_buffer
    import pipeline_stage_buffer_pkg::*;
#(
    parameter int DATA_W = PSB_DATA_W,
    parameter int CTRL_W = PSB_CTRL_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = PSB_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    if (SKID == 0) begin : g_single
        logic              valid_q, valid_d;
        logic [CTRL_W-1:0] ctrl_q, ctrl_d;
        logic [DATA_W-1:0] data_q, data_d;
        logic              in_xfer;
        logic              out_xfer;

        // Payload is deliberately left alone when the slot empties; only control is scrubbed.
        always_comb begin
            valid_d  = valid_q;
            ctrl_d   = ctrl_q;
            data_d   = data_q;
            in_xfer  = in_valid & in_ready;
            out_xfer = valid_q & out_ready;
            if (flush) begin
                valid_d = 1'b0;
                ctrl_d  = '0;
            end else if (in_xfer) begin
                valid_d = 1'b1;
                ctrl_d  = in_ctrl;
                data_d  = in_data;
            end else if (out_xfer) begin
                valid_d = 1'b0;
                ctrl_d  = '0;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                valid_q <= 1'b0;
                ctrl_q  <= '0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                ctrl_q  <= ctrl_d;
                data_q  <= data_d;
            end
        end

        assign in_ready  = out_ready | ~valid_q;
        assign out_valid = valid_q;
        assign out_ctrl  = ctrl_q;
        assign out_data  = data_q;
    end else begin : g_skid
        psb_state_e        state_q, state_d;
        logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
        logic [DATA_W-1:0] main_data_q, main_data_d;
        logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
        logic [DATA_W-1:0] skid_data_q, skid_data_d;
        logic              in_ready_q, in_ready_d;
        logic              in_xfer;
        logic              out_xfer;

        // The skid slot only ever holds the younger entry, so draining it into main keeps order.
        always_comb begin
            state_d     = state_q;
            main_ctrl_d = main_ctrl_q;
            main_data_d = main_data_q;
            skid_ctrl_d = skid_ctrl_q;
            skid_data_d = skid_data_q;
            in_xfer     = in_valid & in_ready_q;
            out_xfer    = (state_q != PSB_EMPTY) & out_ready;
            if (flush) begin
                state_d     = PSB_EMPTY;
                main_ctrl_d = '0;
                skid_ctrl_d = '0;
            end else begin
                case (state_q)
                    PSB_EMPTY: begin
                        if (in_xfer) begin
                            state_d     = PSB_FULL;
                            main_ctrl_d = in_ctrl;
                            main_data_d = in_data;
                        end
                    end
                    PSB_FULL: begin
                        if (in_xfer && out_xfer) begin
                            main_ctrl_d = in_ctrl;
                            main_data_d = in_data;
                        end else if (out_xfer) begin
                            state_d     = PSB_EMPTY;
                            main_ctrl_d = '0;
                        end else if (in_xfer) begin
                            state_d     = PSB_SKIDDED;
                            skid_ctrl_d = in_ctrl;
                            skid_data_d = in_data;
                        end
                    end
                    PSB_SKIDDED: begin
                        if (out_xfer) begin
                            state_d     = PSB_FULL;
                            main_ctrl_d = skid_ctrl_q;
                            main_data_d = skid_data_q;
                            skid_ctrl_d = '0;
                        end
                    end
                    default: begin
                        state_d     = PSB_EMPTY;
                        main_ctrl_d = '0;
                    end
                endcase
            end
            in_ready_d = (state_d != PSB_SKIDDED);
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q     <= PSB_EMPTY;
                main_ctrl_q <= '0;
                main_data_q <= '0;
                skid_ctrl_q <= '0;
                skid_data_q <= '0;
                in_ready_q  <= 1'b1;
            end else begin
                state_q     <= state_d;
                main_ctrl_q <= main_ctrl_d;
                main_data_q <= main_data_d;
                skid_ctrl_q <= skid_ctrl_d;
                skid_data_q <= skid_data_d;
                in_ready_q  <= in_ready_d;
            end
        end

        assign in_ready  = in_ready_q;
        assign out_valid = (state_q != PSB_EMPTY);
        assign out_ctrl  = main_ctrl_q;
        assign out_data  = main_data_q;
    end

    logic stall_inc;
    logic flush_inc;

    assign stall_inc = out_valid & ~out_ready;
    assign flush_inc = flush & out_valid;

    pipeline_stage_buffer_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

    pipeline_stage_buffer_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .cnt (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_stage_buffer.sv
// Checks the stage buffer with and without skid, plus a narrow-counter instance for saturation.
module tb_pipeline_stage_buffer;

    typedef struct packed {
        logic [7:0]  ctrl;
        logic [31:0] data;
    } entry_t;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [7:0]  ctrl;
        logic [31:0] data;
        logic        exp_valid;
        logic [7:0]  exp_ctrl;
        logic [31:0] exp_data;
        logic        exp_ready;
        logic [15:0] exp_stall;
        logic [15:0] exp_flush;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [7:0]  in_ctrl   [3];
    logic [31:0] in_data   [3];
    logic        flush     [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [7:0]  out_ctrl  [3];
    logic [31:0] out_data  [3];
    logic [15:0] stall_cnt [2];
    logic [15:0] flush_cnt [2];
    logic [3:0]  stall4;
    logic [3:0]  flush4;

    int checks   = 0;
    int failures = 0;
    vec_t tbl [15];

    pipeline_stage_buffer #(.DATA_W(32), .CTRL_W(8), .SKID(0), .CNT_W(16)) dut_s0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_ctrl(in_ctrl[0]), .in_data(in_data[0]), .flush(flush[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_ctrl(out_ctrl[0]),
        .out_data(out_data[0]), .stall_cnt(stall_cnt[0]), .flush_cnt(flush_cnt[0])
    );

    pipeline_stage_buffer #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(16)) dut_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_ctrl(in_ctrl[1]), .in_data(in_data[1]), .flush(flush[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_ctrl(out_ctrl[1]),
        .out_data(out_data[1]), .stall_cnt(stall_cnt[1]), .flush_cnt(flush_cnt[1])
    );

    pipeline_stage_buffer #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(4)) dut_c4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_ctrl(in_ctrl[2]), .in_data(in_data[2]), .flush(flush[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_ctrl(out_ctrl[2]),
        .out_data(out_data[2]), .stall_cnt(stall4), .flush_cnt(flush4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic iv, input logic ordy, input logic fl,
                                   input logic [7:0] c, input logic [31:0] dt,
                                   input logic ev, input logic [7:0] ec, input logic [31:0] ed,
                                   input logic er, input logic [15:0] es, input logic [15:0] ef);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.ctrl = c; v.data = dt;
        v.exp_valid = ev; v.exp_ctrl = ec; v.exp_data = ed;
        v.exp_ready = er; v.exp_stall = es; v.exp_flush = ef;
        return v;
    endfunction

    task automatic applyStimulus(input int d, input logic iv, input logic ordy, input logic fl,
                                 input logic [7:0] c, input logic [31:0] dt);
        @(negedge clk);
        in_valid[d]  = iv;
        out_ready[d] = ordy;
        flush[d]     = fl;
        in_ctrl[d]   = c;
        in_data[d]   = dt;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0; out_ready[k] = 1'b0; flush[k] = 1'b0;
            in_ctrl[k] = '0; in_data[k] = '0;
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Reset asserted between edges must clear everything immediately.
    task automatic runMidReset(input int d);
        string p;
        p = $sformatf("rst%0d", d);
        doReset();
        applyStimulus(d, 1'b1, 1'b0, 1'b0, 8'h55, 32'h1234);
        applyStimulus(d, 1'b1, 1'b0, 1'b0, 8'h56, 32'h5678);
        @(posedge clk); #1;
        checkOutput({p, "_pre_valid"}, 32'(out_valid[d]), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput({p, "_valid"}, 32'(out_valid[d]), 32'd0);
        checkOutput({p, "_ctrl"}, 32'(out_ctrl[d]), 32'd0);
        checkOutput({p, "_data"}, out_data[d], 32'd0);
        checkOutput({p, "_stall"}, 32'(stall_cnt[d]), 32'd0);
        checkOutput({p, "_flush"}, 32'(flush_cnt[d]), 32'd0);
        @(negedge clk);
        in_valid[d] = 1'b0; out_ready[d] = 1'b0;
        checkOutput({p, "_in_ready"}, 32'(in_ready[d]), 32'd1);
        rst = 1'b1;
    endtask

    task automatic runStream(input int d);
        doReset();
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(d, 1'b1, 1'b1, 1'b0, 8'(i), 32'(i));
            @(posedge clk); #1;
            checkOutput($sformatf("stream%0d_valid_%0d", d, i), 32'(out_valid[d]), 32'd1);
            checkOutput($sformatf("stream%0d_data_%0d", d, i), out_data[d], 32'(i));
            checkOutput($sformatf("stream%0d_ctrl_%0d", d, i), 32'(out_ctrl[d]), 32'(i));
        end
        applyStimulus(d, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0);
        @(posedge clk); #1;
        checkOutput($sformatf("stream%0d_drain", d), 32'(out_valid[d]), 32'd0);
    endtask

    // Reference: an ordered queue with capacity 1 (no skid) or 2 (skid).
    task automatic runRandom(input int d, input int cycles);
        entry_t      mq[$];
        entry_t      e;
        logic [31:0] last_data;
        int          m_stall;
        int          m_flush;
        logic        m_ready;
        logic        iv, ordy, fl, exp_ready, in_x, out_x;
        doReset();
        last_data = '0; m_stall = 0; m_flush = 0; m_ready = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            e.ctrl = 8'($urandom);
            e.data = $urandom;
            iv   = ($urandom_range(99) < 70);
            ordy = ($urandom_range(99) < 60);
            fl   = ($urandom_range(99) < 7);
            applyStimulus(d, iv, ordy, fl, e.ctrl, e.data);
            #1;
            exp_ready = (d == 0) ? (ordy || mq.size() == 0) : m_ready;
            checkOutput("rand_in_ready", 32'(in_ready[d]), 32'(exp_ready));
            checkOutput("rand_out_valid", 32'(out_valid[d]), 32'(mq.size() != 0));
            checkOutput("rand_out_ctrl", 32'(out_ctrl[d]), (mq.size() != 0) ? 32'(mq[0].ctrl) : 32'd0);
            checkOutput("rand_out_data", out_data[d], (mq.size() != 0) ? mq[0].data : last_data);
            checkOutput("rand_stall_cnt", 32'(stall_cnt[d]), 32'(m_stall));
            checkOutput("rand_flush_cnt", 32'(flush_cnt[d]), 32'(m_flush));
            in_x  = iv && exp_ready;
            out_x = (mq.size() != 0) && ordy;
            if (mq.size() != 0 && !ordy && m_stall < 65535) m_stall++;
            if (fl && mq.size() != 0 && m_flush < 65535) m_flush++;
            if (fl) begin
                mq.delete();
            end else begin
                if (out_x) void'(mq.pop_front());
                if (in_x) mq.push_back(e);
            end
            if (mq.size() != 0) last_data = mq[0].data;
            m_ready = (mq.size() < 2);
            @(posedge clk);
        end
    endtask

    initial begin
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0; out_ready[k] = 1'b0; flush[k] = 1'b0;
            in_ctrl[k] = '0; in_data[k] = '0;
        end

        //           iv    ordy  fl    ctrl   data      valid ctrl   data      rdy   stall  flush
        tbl[0]  = mkVec(1'b1, 1'b1, 1'b0, 8'h1A, 32'hA,  1'b1, 8'h1A, 32'hA,  1'b1, 16'd0, 16'd0);
        tbl[1]  = mkVec(1'b1, 1'b0, 1'b0, 8'h1B, 32'hB,  1'b1, 8'h1A, 32'hA,  1'b0, 16'd1, 16'd0);
        tbl[2]  = mkVec(1'b0, 1'b0, 1'b0, 8'h00, 32'h0,  1'b1, 8'h1A, 32'hA,  1'b0, 16'd2, 16'd0);
        tbl[3]  = mkVec(1'b0, 1'b0, 1'b0, 8'h00, 32'h0,  1'b1, 8'h1A, 32'hA,  1'b0, 16'd3, 16'd0);
        tbl[4]  = mkVec(1'b0, 1'b0, 1'b0, 8'h00, 32'h0,  1'b1, 8'h1A, 32'hA,  1'b0, 16'd4, 16'd0);
        tbl[5]  = mkVec(1'b0, 1'b0, 1'b0, 8'h00, 32'h0,  1'b1, 8'h1A, 32'hA,  1'b0, 16'd5, 16'd0);
        tbl[6]  = mkVec(1'b0, 1'b1, 1'b0, 8'h00, 32'h0,  1'b1, 8'h1B, 32'hB,  1'b1, 16'd5, 16'd0);
        tbl[7]  = mkVec(1'b0, 1'b1, 1'b0, 8'h00, 32'h0,  1'b0, 8'h00, 32'hB,  1'b1, 16'd5, 16'd0);
        tbl[8]  = mkVec(1'b1, 1'b0, 1'b0, 8'h1D, 32'hD,  1'b1, 8'h1D, 32'hD,  1'b1, 16'd5, 16'd0);
        tbl[9]  = mkVec(1'b1, 1'b0, 1'b0, 8'h1E, 32'hE,  1'b1, 8'h1D, 32'hD,  1'b0, 16'd6, 16'd0);
        tbl[10] = mkVec(1'b1, 1'b0, 1'b1, 8'h1C, 32'hC,  1'b0, 8'h00, 32'hD,  1'b1, 16'd7, 16'd1);
        tbl[11] = mkVec(1'b0, 1'b1, 1'b1, 8'h00, 32'h0,  1'b0, 8'h00, 32'hD,  1'b1, 16'd7, 16'd1);
        tbl[12] = mkVec(1'b1, 1'b0, 1'b1, 8'h1F, 32'hF,  1'b0, 8'h00, 32'hD,  1'b1, 16'd7, 16'd1);
        tbl[13] = mkVec(1'b1, 1'b1, 1'b0, 8'h42, 32'h42, 1'b1, 8'h42, 32'h42, 1'b1, 16'd7, 16'd1);
        tbl[14] = mkVec(1'b1, 1'b1, 1'b1, 8'h43, 32'h43, 1'b0, 8'h00, 32'h42, 1'b1, 16'd7, 16'd2);

        runMidReset(0);
        runMidReset(1);
        runStream(0);
        runStream(1);

        // Skid fill, stall, release, then flush out of SKIDDED and flushes on an empty stage.
        doReset();
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1, tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].ctrl, tbl[i].data);
            @(posedge clk); #1;
            checkOutput($sformatf("tbl%0d_out_valid", i), 32'(out_valid[1]), 32'(tbl[i].exp_valid));
            checkOutput($sformatf("tbl%0d_out_ctrl", i), 32'(out_ctrl[1]), 32'(tbl[i].exp_ctrl));
            checkOutput($sformatf("tbl%0d_out_data", i), out_data[1], tbl[i].exp_data);
            checkOutput($sformatf("tbl%0d_in_ready", i), 32'(in_ready[1]), 32'(tbl[i].exp_ready));
            checkOutput($sformatf("tbl%0d_stall_cnt", i), 32'(stall_cnt[1]), 32'(tbl[i].exp_stall));
            checkOutput($sformatf("tbl%0d_flush_cnt", i), 32'(flush_cnt[1]), 32'(tbl[i].exp_flush));
        end

        doReset();
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0);
        #1;
        checkOutput("s0_empty_flush_in_ready", 32'(in_ready[0]), 32'd1);
        @(posedge clk); #1;
        checkOutput("s0_empty_flush_cnt", 32'(flush_cnt[0]), 32'd0);
        checkOutput("s0_empty_flush_valid", 32'(out_valid[0]), 32'd0);

        doReset();
        applyStimulus(2, 1'b1, 1'b0, 1'b0, 8'h77, 32'h77);
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(2, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
            @(posedge clk); #1;
            checkOutput($sformatf("sat_stall_%0d", i), 32'(stall4), (i < 15) ? 32'(i) : 32'd15);
        end
        checkOutput("sat_flush_idle", 32'(flush4), 32'd0);

        runRandom(0, 400);
        runRandom(1, 400);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
